// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES-128 round datapath: accepts a block, strobes
// load / per-round update / key-step, flags the final round and hands the result downstream.
module aes_round_sequencer #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             load_en,
    output logic             round_en,
    output logic             key_step,
    output logic [3:0]       round_idx,
    output logic             mix_bypass,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blk_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] NR_IDX    = 4'(NR);
    localparam logic [2:0] WCNT_LAST = 3'(ROUND_LAT - 1);

    state_t             state_q, state_d;
    logic [3:0]         round_idx_q, round_idx_d;
    logic [2:0]         wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;

    logic in_ready_c, load_en_c, round_en_c, key_step_c;
    logic mix_bypass_c, busy_c, out_valid_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_idx_q <= 4'd0;
            wcnt_q      <= 3'd0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            wcnt_q      <= wcnt_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        round_idx_d  = round_idx_q;
        wcnt_d       = wcnt_q;
        blk_cnt_d    = blk_cnt_q;
        in_ready_c   = 1'b0;
        load_en_c    = 1'b0;
        round_en_c   = 1'b0;
        key_step_c   = 1'b0;
        mix_bypass_c = 1'b0;
        busy_c       = 1'b0;
        out_valid_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (in_valid) begin
                    state_d     = S_LOAD;
                    round_idx_d = 4'd0;
                    wcnt_d      = 3'd0;
                end
            end
            S_LOAD: begin
                load_en_c   = 1'b1;
                key_step_c  = 1'b1;
                busy_c      = 1'b1;
                state_d     = S_ROUND;
                round_idx_d = 4'd1;
                wcnt_d      = 3'd0;
            end
            S_ROUND: begin
                busy_c       = 1'b1;
                mix_bypass_c = (round_idx_q == NR_IDX);
                if (wcnt_q == WCNT_LAST) begin
                    round_en_c = 1'b1;
                    wcnt_d     = 3'd0;
                    // The last round needs no further round key.
                    if (round_idx_q == NR_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        key_step_c  = 1'b1;
                        round_idx_d = round_idx_q + 4'd1;
                    end
                end else begin
                    wcnt_d = wcnt_q + 3'd1;
                end
            end
            S_DONE: begin
                out_valid_c = 1'b1;
                if (out_ready) begin
                    blk_cnt_d   = blk_cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                    round_idx_d = 4'd0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                round_idx_d = 4'd0;
                wcnt_d      = 3'd0;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, even before the first reset edge.
    assign in_ready   = in_ready_c   & ~rst;
    assign load_en    = load_en_c    & ~rst;
    assign round_en   = round_en_c   & ~rst;
    assign key_step   = key_step_c   & ~rst;
    assign mix_bypass = mix_bypass_c & ~rst;
    assign busy       = busy_c       & ~rst;
    assign out_valid  = out_valid_c  & ~rst;
    assign round_idx  = rst ? 4'd0 : round_idx_q;
    assign blk_cnt    = rst ? '0 : blk_cnt_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: table vectors, directed corner sequences and random
// traffic against a transaction-offset reference model; three parameterisations.
module tb_aes_round_sequencer;

    localparam int NR_A  = 10;
    localparam int LAT_A = 1;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic a_rst, a_iv, a_or, a_ir, a_le, a_re, a_ks, a_mb, a_bs, a_ov;
    logic [3:0]  a_ri;
    logic [15:0] a_bc;
    // Instance B: ROUND_LAT=2
    logic b_rst, b_iv, b_or, b_ir, b_le, b_re, b_ks, b_mb, b_bs, b_ov;
    logic [3:0]  b_ri;
    logic [15:0] b_bc;
    // Instance C: CNT_W=2
    logic c_rst, c_iv, c_or, c_ir, c_le, c_re, c_ks, c_mb, c_bs, c_ov;
    logic [3:0]  c_ri;
    logic [1:0]  c_bc;

    aes_round_sequencer dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir), .load_en(a_le),
        .round_en(a_re), .key_step(a_ks), .round_idx(a_ri), .mix_bypass(a_mb),
        .busy(a_bs), .out_valid(a_ov), .out_ready(a_or), .blk_cnt(a_bc)
    );

    aes_round_sequencer #(.NR(10), .ROUND_LAT(2), .CNT_W(16)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_ir), .load_en(b_le),
        .round_en(b_re), .key_step(b_ks), .round_idx(b_ri), .mix_bypass(b_mb),
        .busy(b_bs), .out_valid(b_ov), .out_ready(b_or), .blk_cnt(b_bc)
    );

    aes_round_sequencer #(.NR(10), .ROUND_LAT(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(c_rst), .in_valid(c_iv), .in_ready(c_ir), .load_en(c_le),
        .round_en(c_re), .key_step(c_ks), .round_idx(c_ri), .mix_bypass(c_mb),
        .busy(c_bs), .out_valid(c_ov), .out_ready(c_or), .blk_cnt(c_bc)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Control vector order: {in_ready, load_en, round_en, key_step, mix_bypass, busy, out_valid}
    function automatic int mk(input int ir, le, re, ks, mb, bs, ov);
        return (ir << 6) | (le << 5) | (re << 4) | (ks << 3) | (mb << 2) | (bs << 1) | ov;
    endfunction

    function automatic int a_vec();
        return mk(int'(a_ir), int'(a_le), int'(a_re), int'(a_ks), int'(a_mb), int'(a_bs), int'(a_ov));
    endfunction

    // Reference model: a block is described only by the cycle it was accepted in;
    // everything else follows from the offset k = cycle - accept_cycle.
    bit m_busy = 1'b0;
    int m_tacc = 0;
    int m_blk  = 0;
    int cyc    = 0;

    task automatic model_exp(output int vec, output int ridx, output int blk);
        int k, j, r;
        vec = 0; ridx = 0; blk = 0;
        if (a_rst) return;
        blk = m_blk;
        k = cyc - m_tacc;
        if (!m_busy) begin
            vec = mk(1, 0, 0, 0, 0, 0, 0);
        end else if (k == 1) begin
            vec = mk(0, 1, 0, 1, 0, 1, 0);
        end else if (k <= 1 + NR_A * LAT_A) begin
            j = k - 2;
            r = j / LAT_A + 1;
            vec = mk(0, 0, int'(j % LAT_A == LAT_A - 1),
                     int'((j % LAT_A == LAT_A - 1) && r < NR_A), int'(r == NR_A), 1, 0);
            ridx = r;
        end else begin
            vec = mk(0, 0, 0, 0, 0, 0, 1);
            ridx = NR_A;
        end
    endtask

    task automatic a_step(input bit r, input bit iv, input bit ordy);
        int ev, er, eb;
        a_rst = r; a_iv = iv; a_or = ordy;
        #1;
        model_exp(ev, er, eb);
        chk("a_ctl", a_vec(), ev);
        chk("a_round_idx", int'(a_ri), er);
        chk("a_blk_cnt", int'(a_bc), eb);
        chk("a_excl", int'((int'(a_le) + int'(a_re) + int'(a_ov)) <= 1), 1);
    endtask

    task automatic a_next();
        int k;
        k = cyc - m_tacc;
        if (a_rst) begin
            m_busy = 1'b0; m_blk = 0;
        end else if (!m_busy && a_iv) begin
            m_busy = 1'b1; m_tacc = cyc;
        end else if (m_busy && k > 1 + NR_A * LAT_A && a_or) begin
            m_busy = 1'b0; m_blk = (m_blk + 1) % 65536;
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic a_cycle(input bit r, input bit iv, input bit ordy);
        a_step(r, iv, ordy);
        a_next();
    endtask

    typedef struct {
        bit rst, iv, ordy;
        int vec, ridx, blk;
    } vec_t;
    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found, saw, lat, n, re_cnt, ks_cnt, first_ov, prev_ov, last_hs;
        int exp_cnt[5] = '{1, 2, 3, 0, 1};

        a_rst = 1; a_iv = 1; a_or = 0;
        b_rst = 1; b_iv = 0; b_or = 0;
        c_rst = 1; c_iv = 0; c_or = 0;

        // T1 reset + T2 single block, cycle by cycle
        for (int i = 0; i < 3; i++) tbl[i] = '{1, 1, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0), 0, 0};
        tbl[4] = '{0, 1, 1, mk(1, 0, 0, 0, 0, 0, 0), 0, 0};
        tbl[5] = '{0, 0, 1, mk(0, 1, 0, 1, 0, 1, 0), 0, 0};
        for (int r = 1; r <= 10; r++)
            tbl[5 + r] = '{0, 0, 1, mk(0, 0, 1, int'(r < 10), int'(r == 10), 1, 0), r, 0};
        tbl[16] = '{0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1), 10, 0};
        tbl[17] = '{0, 0, 1, mk(1, 0, 0, 0, 0, 0, 0), 0, 1};

        for (int i = 0; i < 18; i++) begin
            a_rst = tbl[i].rst; a_iv = tbl[i].iv; a_or = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ctl", i), a_vec(), tbl[i].vec);
            chk($sformatf("tbl%0d_round_idx", i), int'(a_ri), tbl[i].ridx);
            chk($sformatf("tbl%0d_blk_cnt", i), int'(a_bc), tbl[i].blk);
            @(posedge clk); #1;
        end

        // T4 backpressure with in_valid held high
        a_cycle(1, 0, 0);
        a_step(0, 1, 0); chk("t4_accept_rdy", int'(a_ir), 1); a_next();
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            a_step(0, 1, 0);
            if (a_ov) found = 1;
            a_next();
        end
        chk("t4_reached_done", found, 1);
        for (int i = 0; i < 4; i++) begin
            a_step(0, 1, 0);
            chk("t4_hold_ov", int'(a_ov), 1);
            chk("t4_hold_idx", int'(a_ri), 10);
            chk("t4_hold_rdy", int'(a_ir), 0);
            a_next();
        end
        a_step(0, 1, 1); chk("t4_hs_ov", int'(a_ov), 1); a_next();
        a_step(0, 1, 1); chk("t4_rdy_after_hs", int'(a_ir), 1); chk("t4_blk", int'(a_bc), 1); a_next();
        a_step(0, 0, 1); chk("t4_second_load", int'(a_le), 1); a_next();
        for (int i = 0; i < 14; i++) a_cycle(0, 0, 1);

        // T5 abort at round 5
        a_cycle(0, 1, 1);
        for (int i = 1; i <= 5; i++) begin
            a_step(0, 0, 1);
            if (i == 5) chk("t5_pre_idx", int'(a_ri), 4);
            a_next();
        end
        a_cycle(1, 0, 1);
        a_step(0, 0, 1);
        chk("t5_idle_rdy", int'(a_ir), 1);
        chk("t5_idle_idx", int'(a_ri), 0);
        chk("t5_idle_blk", int'(a_bc), 0);
        a_next();
        saw = 0;
        for (int i = 0; i < 20; i++) begin
            a_step(0, 0, 1);
            if (a_ov) saw = 1;
            a_next();
        end
        chk("t5_no_out_valid", saw, 0);
        a_cycle(0, 1, 1);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            a_step(0, 0, 1);
            if (a_ov && lat == 0) lat = i;
            a_next();
        end
        chk("t5_latency", lat, 12);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++)
            a_cycle(($urandom % 250) == 0, ($urandom % 3) != 0, ($urandom % 4) != 0);

        // T3 ROUND_LAT=2
        @(posedge clk); #1;
        b_rst = 0; b_iv = 1; b_or = 1;
        #1 chk("t3_rdy", int'(b_ir), 1);
        @(posedge clk); #1;
        b_iv = 0;
        re_cnt = 0; ks_cnt = 0; first_ov = 0;
        for (int k = 1; k <= 24; k++) begin
            #1;
            chk($sformatf("t3_round_en_k%0d", k), int'(b_re),
                int'(k >= 3 && k <= 21 && (k % 2) == 1));
            chk("t3_excl", int'((int'(b_le) + int'(b_re) + int'(b_ov)) <= 1), 1);
            re_cnt += int'(b_re);
            ks_cnt += int'(b_ks);
            if (b_ov && first_ov == 0) first_ov = k;
            @(posedge clk); #1;
        end
        chk("t3_round_pulses", re_cnt, 10);
        chk("t3_key_pulses", ks_cnt, 10);
        chk("t3_out_valid_at", first_ov, 22);

        // T6 counter wrap with CNT_W=2, back-to-back blocks
        @(posedge clk); #1;
        c_rst = 0; c_iv = 1; c_or = 1;
        n = 0; prev_ov = 0; last_hs = -1;
        for (int i = 0; i < 100 && n < 5; i++) begin
            #1;
            if (prev_ov != 0) begin
                chk($sformatf("t6_blk_cnt%0d", n), int'(c_bc), exp_cnt[n]);
                n++;
            end
            if (c_ov) begin
                if (last_hs >= 0) chk("t6_spacing", i - last_hs, 13);
                last_hs = i;
            end
            chk("t6_excl", int'((int'(c_le) + int'(c_re) + int'(c_ov)) <= 1), 1);
            prev_ov = int'(c_ov);
            @(posedge clk); #1;
        end
        chk("t6_blocks_done", n, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
